// File: rtl/vrased_pkg.sv
// ============================================================================
// Module : vrased_pkg
// Shared types and constants for the VRASED reset-sequencing logic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vrased_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_HOLD         = 2'd1,
        ST_WAIT_HANDLER = 2'd2
    } state_t;

    localparam int VIOL_X_STACK     = 0;
    localparam int VIOL_AC          = 1;
    localparam int VIOL_ATOMICITY   = 2;
    localparam int VIOL_DMA_AC      = 3;
    localparam int VIOL_DMA_DETECT  = 4;
    localparam int VIOL_DMA_X_STACK = 5;
    localparam int VIOL_WIDTH       = 6;

    localparam int          DEFAULT_HOLD_CYCLES   = 4;
    localparam logic [15:0] DEFAULT_RESET_HANDLER = 16'h0000;
    localparam int          TIMER_WIDTH           = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vrased_hold_timer.sv
// ============================================================================
// Module : vrased_hold_timer
// Loadable down-counter with enable and zero flag; stops at zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vrased_hold_timer
    import vrased_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_val,
    input  logic                   en,
    output logic                   zero
);

    logic [TIMER_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/vrased_reset_seq.sv
// ============================================================================
// Module : vrased_reset_seq
// Turns monitor violations into a timed processor reset and waits for the
// CPU to reach the reset handler before re-arming.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vrased_reset_seq
    import vrased_pkg::*;
#(
    parameter int          HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter logic [15:0] RESET_HANDLER = DEFAULT_RESET_HANDLER
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VIOL_WIDTH-1:0] viol,
    input  logic [15:0]           pc,
    output logic                  sys_reset,
    output logic [VIOL_WIDTH-1:0] cause,
    output logic [7:0]            viol_cnt,
    output logic                  busy
);

    localparam logic [TIMER_WIDTH-1:0] C_HOLD_LOAD = TIMER_WIDTH'(HOLD_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_timer_load;
    logic                  w_timer_en;
    logic                  w_timer_zero;
    logic [VIOL_WIDTH-1:0] w_cause_nxt;
    logic [7:0]            w_cnt_nxt;
    logic                  w_viol_any;
    logic                  w_pc_match;

    assign w_viol_any = |viol;
    assign w_pc_match = (pc == RESET_HANDLER);

    vrased_hold_timer u_hold_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (w_timer_load),
        .load_val (C_HOLD_LOAD),
        .en       (w_timer_en),
        .zero     (w_timer_zero)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;
        w_cause_nxt  = cause;
        w_cnt_nxt    = viol_cnt;
        case (r_state)
            ST_IDLE: begin
                // A new episode replaces the cause; later hits only accumulate.
                if (w_viol_any) begin
                    w_state_nxt  = ST_HOLD;
                    w_timer_load = 1'b1;
                    w_cause_nxt  = viol;
                    w_cnt_nxt    = sat_inc8(viol_cnt);
                end
            end
            ST_HOLD: begin
                w_cause_nxt = cause | viol;
                if (w_timer_zero) begin
                    w_state_nxt = ST_WAIT_HANDLER;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            ST_WAIT_HANDLER: begin
                if (w_viol_any) begin
                    w_state_nxt  = ST_HOLD;
                    w_timer_load = 1'b1;
                    w_cause_nxt  = cause | viol;
                end else if (w_pc_match) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state register without any combinational path to ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            sys_reset <= 1'b0;
            busy      <= 1'b0;
            cause     <= '0;
            viol_cnt  <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            sys_reset <= (w_state_nxt == ST_HOLD);
            busy      <= (w_state_nxt != ST_IDLE);
            cause     <= w_cause_nxt;
            viol_cnt  <= w_cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vrased_reset_seq.sv
// ============================================================================
// Module : tb_vrased_reset_seq
// Directed scenarios plus randomized traffic against an episode-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vrased_reset_seq;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic [5:0]  viol, viol2;
    logic [15:0] pc, pc2;
    logic        sys_reset, sys_reset2, busy, busy2;
    logic [5:0]  cause, cause2;
    logic [7:0]  viol_cnt, viol_cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vrased_reset_seq dut (
        .clk(clk), .reset(reset), .viol(viol), .pc(pc),
        .sys_reset(sys_reset), .cause(cause), .viol_cnt(viol_cnt), .busy(busy)
    );

    vrased_reset_seq #(.HOLD_CYCLES(1), .RESET_HANDLER(16'h0000)) dut1 (
        .clk(clk), .reset(reset2), .viol(viol2), .pc(pc2),
        .sys_reset(sys_reset2), .cause(cause2), .viol_cnt(viol_cnt2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; viol = '0; pc = 16'h1234;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; viol = 6'h3F; pc = 16'h0000;
        tick(); tick();
        n_vec++; if (sys_reset !== 1'b0) begin n_err++; $display("FAIL reset_sys_reset got=%0b exp=0", sys_reset); end
        n_vec++; if (cause !== 6'h00) begin n_err++; $display("FAIL reset_cause got=%h exp=00", cause); end
        n_vec++; if (viol_cnt !== 8'h00) begin n_err++; $display("FAIL reset_cnt got=%h exp=00", viol_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        reset = 1'b0; viol = '0;
    endtask

    task automatic test_single_violation();
        do_reset();
        viol = 6'b000010; tick(); viol = '0;
        n_vec++; if (cause !== 6'h02) begin n_err++; $display("FAIL single_cause got=%h exp=02", cause); end
        n_vec++; if (viol_cnt !== 8'h01) begin n_err++; $display("FAIL single_cnt got=%h exp=01", viol_cnt); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (sys_reset !== (i < 4)) begin n_err++; $display("FAIL single_width cyc=%0d got=%0b exp=%0b", i, sys_reset, (i < 4)); end
            tick();
        end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_wait got=%0b exp=1", busy); end
        pc = 16'h0000; tick(); pc = 16'h1234;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done got=%0b exp=0", busy); end
        // In IDLE the handler address must not disturb anything.
        pc = 16'h0000; tick(); tick(); pc = 16'h1234;
        n_vec++; if ({busy, sys_reset, viol_cnt} !== {1'b0, 1'b0, 8'h01}) begin n_err++; $display("FAIL idle_pc got=%b_%b_%h exp=0_0_01", busy, sys_reset, viol_cnt); end
    endtask

    task automatic test_merge_in_hold();
        int width = 0;
        do_reset();
        viol = 6'h01; tick(); if (sys_reset) width++;
        viol = 6'h00; tick(); if (sys_reset) width++;
        viol = 6'h20; tick(); if (sys_reset) width++;
        viol = 6'h00;
        for (int i = 0; i < 8; i++) begin tick(); if (sys_reset) width++; end
        n_vec++; if (width !== 4) begin n_err++; $display("FAIL merge_width got=%0d exp=4", width); end
        n_vec++; if (cause !== 6'h21) begin n_err++; $display("FAIL merge_cause got=%h exp=21", cause); end
        n_vec++; if (viol_cnt !== 8'h01) begin n_err++; $display("FAIL merge_cnt got=%h exp=01", viol_cnt); end
    endtask

    task automatic test_reviolation_in_wait();
        int width = 0;
        do_reset();
        viol = 6'h01; tick(); viol = '0;
        for (int i = 0; i < 6; i++) tick();
        n_vec++; if ({busy, sys_reset} !== 2'b10) begin n_err++; $display("FAIL rewait_pre got=%b exp=10", {busy, sys_reset}); end
        viol = 6'h08; pc = 16'h0000; tick(); viol = '0; pc = 16'h1234;
        if (sys_reset) width++;
        n_vec++; if (cause !== 6'h09) begin n_err++; $display("FAIL rewait_cause got=%h exp=09", cause); end
        n_vec++; if (viol_cnt !== 8'h01) begin n_err++; $display("FAIL rewait_cnt got=%h exp=01", viol_cnt); end
        for (int i = 0; i < 8; i++) begin tick(); if (sys_reset) width++; end
        n_vec++; if (width !== 4) begin n_err++; $display("FAIL rewait_width got=%0d exp=4", width); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rewait_busy got=%0b exp=1", busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int ep = 1; ep <= 260; ep++) begin
            viol = 6'($urandom_range(1, 63)); tick();
            viol = '0; pc = 16'h0000;
            for (int k = 0; k < 5; k++) tick();
            pc = 16'h1234;
            if (ep == 254 || ep == 255 || ep == 260) begin
                n_vec++;
                if (viol_cnt !== ((ep >= 255) ? 8'hFF : 8'(ep))) begin
                    n_err++; $display("FAIL sat_cnt ep=%0d got=%h exp=%h", ep, viol_cnt, (ep >= 255) ? 8'hFF : 8'(ep));
                end
            end
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        viol = 6'h04; tick(); viol = '0; tick();
        reset = 1'b1; viol = 6'h03; tick();
        n_vec++; if ({sys_reset, busy, cause, viol_cnt} !== 16'h0000) begin
            n_err++; $display("FAIL midhold_reset got=%b_%b_%h_%h exp=0_0_00_00", sys_reset, busy, cause, viol_cnt);
        end
        reset = 1'b0; viol = '0; tick();
        n_vec++; if ({sys_reset, busy} !== 2'b00) begin n_err++; $display("FAIL midhold_after got=%b exp=00", {sys_reset, busy}); end
    endtask

    task automatic test_hold_one();
        reset2 = 1'b1; viol2 = '0; pc2 = 16'h4321; tick();
        viol2 = 6'h05; tick();
        n_vec++; if ({sys_reset2, busy2, viol_cnt2} !== 10'h000) begin n_err++; $display("FAIL h1_ignored got=%b_%b_%h exp=0_0_00", sys_reset2, busy2, viol_cnt2); end
        reset2 = 1'b0; tick(); viol2 = '0;
        n_vec++; if ({sys_reset2, cause2, viol_cnt2} !== {1'b1, 6'h05, 8'h01}) begin n_err++; $display("FAIL h1_pulse got=%b_%h_%h exp=1_05_01", sys_reset2, cause2, viol_cnt2); end
        tick();
        n_vec++; if ({sys_reset2, busy2} !== 2'b01) begin n_err++; $display("FAIL h1_end got=%b exp=01", {sys_reset2, busy2}); end
        pc2 = 16'h0000; tick(); pc2 = 16'h4321;
        n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL h1_idle got=%0b exp=0", busy2); end
    endtask

    // Model: an episode is either holding (hold_left > 0) or waiting for the handler.
    task automatic test_random();
        int         hold_left = 0;
        bit         in_episode = 0;
        logic [5:0] m_cause = '0;
        int         m_cnt = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 299) == 0);
            viol  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h00;
            pc    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            if (reset) begin
                hold_left = 0; in_episode = 0; m_cause = '0; m_cnt = 0;
            end else if (!in_episode) begin
                if (viol != 0) begin
                    in_episode = 1; hold_left = 4; m_cause = viol;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
            end else if (hold_left > 0) begin
                hold_left--; m_cause |= viol;
            end else if (viol != 0) begin
                hold_left = 4; m_cause |= viol;
            end else if (pc == 16'h0000) begin
                in_episode = 0;
            end
            tick();
            n_vec++;
            if ({sys_reset, busy, cause, viol_cnt} !== {(hold_left > 0), in_episode, m_cause, 8'(m_cnt)}) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%b_%b_%h_%h exp=%b_%b_%h_%h", cyc, sys_reset, busy, cause, viol_cnt,
                         (hold_left > 0), in_episode, m_cause, 8'(m_cnt));
            end
        end
        reset = 1'b0; viol = '0;
    endtask

    initial begin
        reset = 1'b1; viol = '0; pc = 16'h1234;
        reset2 = 1'b1; viol2 = '0; pc2 = 16'h4321;
        test_reset();
        test_single_violation();
        test_merge_in_hold();
        test_reviolation_in_wait();
        test_saturation();
        test_reset_mid_hold();
        test_hold_one();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
